// File: rtl/ram_lsu_pkg.sv
// ram_lsu_pkg: shared types and helpers for the scratch-RAM load/store unit.
//   size_e   : access size encoding carried on req_size
//   state_e  : sequencer states
//   req_t    : request fields latched at acceptance
//   size_bytes / extend : byte count per size, sign/zero extension of loads
package ram_lsu_pkg;

  localparam int MEM_DEPTH_DEF = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_DRAIN,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } req_t;

  // Bytes moved for a size code; code 3 never reaches sequencing.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] sz,
                                         input logic uns);
    case (sz)
      SZ_BYTE: return {{24{~uns & v[7]}}, v[7:0]};
      SZ_HALF: return {{16{~uns & v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction

endpackage

// File: rtl/ram_lsu_if.sv
// ram_lsu_if: core request/response handshake plus the byte-wide RAM strobes.
//   slave  : the load/store unit (takes requests, drives RAM strobes)
//   master : the environment (core issuing requests, RAM returning d_out)
interface ram_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        rmem_rd;
  logic        rmem_wr;
  logic [7:0]  rop_a;
  logic [31:0] rop_b;
  logic [31:0] d_out;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, d_out,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, rmem_rd, rmem_wr, rop_a, rop_b
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, d_out,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, rmem_rd, rmem_wr, rop_a, rop_b
  );
endinterface

// File: rtl/ram_lsu_ext.sv
// ram_lsu_ext: combinational load extender.
//   asm_i   : assembled little-endian load value
//   size_i  : access size code
//   uns_i   : 1 = zero-extend, 0 = sign-extend
//   rdata_o : extended 32-bit result
module ram_lsu_ext
  import ram_lsu_pkg::*;
(
  input  logic [31:0] asm_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] rdata_o
);
  assign rdata_o = extend(asm_i, size_i, uns_i);
endmodule

// File: rtl/ram_lsu.sv
// ram_lsu: load/store sequencer driving a byte-wide scratch RAM.
//   clk, rst_en : clock, asynchronous active-high reset
//   bus         : ram_lsu_if.slave -- request handshake, single-cycle response,
//                 RAM strobes rmem_rd/rmem_wr, write byte rop_a, address rop_b,
//                 read data d_out (byte 0 valid the cycle after a read)
// Optional: define MISALIGN_TRAP_EN to reject misaligned half/word accesses.
// Every output is a register; the comb block computes next-cycle output values.
module ram_lsu
  import ram_lsu_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic    clk,
  input  logic    rst_en,
  ram_lsu_if.slave bus
);

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic [1:0]  cnt_q, cnt_d;     // index of the byte strobed this cycle
  logic [31:0] asm_q, asm_d;
  logic        ready_q, ready_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic [7:0]  rop_a_q, rop_a_d, rop_b_q, rop_b_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic        accept, acc_err, last_byte;
  logic [2:0]  n_acc, n_q;
  logic [8:0]  last_addr;        // 9 bits so addr+3 near 255 cannot wrap
  logic [1:0]  cnt_nxt, cap_idx;
  logic [7:0]  nxt_addr;
  logic [31:0] ext_rdata;
  logic        unused_dout_hi;

  assign unused_dout_hi = ^bus.d_out[31:8];

  assign accept    = ready_q & bus.req_valid;
  assign n_acc     = size_bytes(bus.req_size);
  assign last_addr = {1'b0, bus.req_addr} + {6'b0, n_acc} - 9'd1;
  assign n_q       = size_bytes(req_q.size);
  assign last_byte = (cnt_q == 2'(n_q - 3'd1));
  assign cnt_nxt   = cnt_q + 2'd1;
  assign nxt_addr  = req_q.addr + {6'b0, cnt_nxt};

  always_comb begin
    acc_err = (bus.req_size == 2'd3) || (int'(last_addr) > MEM_DEPTH - 1);
`ifdef MISALIGN_TRAP_EN
    if (bus.req_size == SZ_HALF && bus.req_addr[0])          acc_err = 1'b1;
    if (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b0) acc_err = 1'b1;
`endif
  end

  // Read data trails issue by one cycle: in RD the byte of the previous
  // strobe lands; in DRAIN the final byte (cnt_q still points at it) lands.
  always_comb begin
    asm_d   = asm_q;
    cap_idx = cnt_q - 2'd1;
    case (state_q)
      ST_IDLE:  if (accept) asm_d = '0;
      ST_RD:    if (cnt_q != 2'd0) asm_d[{cap_idx, 3'b000} +: 8] = bus.d_out[7:0];
      ST_DRAIN: asm_d[{cnt_q, 3'b000} +: 8] = bus.d_out[7:0];
      default:  ;
    endcase
  end

  ram_lsu_ext u_ext (
    .asm_i   (asm_d),
    .size_i  (req_q.size),
    .uns_i   (req_q.uns),
    .rdata_o (ext_rdata)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    ready_d     = 1'b0;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    rop_a_d     = '0;
    rop_b_d     = '0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          ready_d     = 1'b0;
          req_d.we    = bus.req_we;
          req_d.size  = bus.req_size;
          req_d.uns   = bus.req_unsigned;
          req_d.addr  = bus.req_addr;
          req_d.wdata = bus.req_wdata;
          cnt_d       = '0;
          if (acc_err) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (bus.req_we) begin
            state_d = ST_WR;
            wr_d    = 1'b1;
            rop_b_d = bus.req_addr;
            rop_a_d = bus.req_wdata[7:0];
          end else begin
            state_d = ST_RD;
            rd_d    = 1'b1;
            rop_b_d = bus.req_addr;
          end
        end
      end
      ST_WR: begin
        if (last_byte) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d   = cnt_nxt;
          wr_d    = 1'b1;
          rop_b_d = nxt_addr;
          rop_a_d = req_q.wdata[{cnt_nxt, 3'b000} +: 8];
        end
      end
      ST_RD: begin
        if (last_byte) begin
          state_d = ST_DRAIN;
        end else begin
          cnt_d   = cnt_nxt;
          rd_d    = 1'b1;
          rop_b_d = nxt_addr;
        end
      end
      ST_DRAIN: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = ext_rdata;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_en) begin
    if (rst_en) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      cnt_q       <= '0;
      asm_q       <= '0;
      ready_q     <= 1'b1;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      rop_a_q     <= '0;
      rop_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      ready_q     <= ready_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      rop_a_q     <= rop_a_d;
      rop_b_q     <= rop_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rmem_rd   = rd_q;
  assign bus.rmem_wr   = wr_q;
  assign bus.rop_a     = rop_a_q;
  assign bus.rop_b     = {24'b0, rop_b_q};
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/ram_lsu.md
Name: ram_lsu

Overview:
- Load/store sequencer that acts as the initiator for the byte-wide scratch RAM.
- Accepts 32-bit byte, half and word load/store requests from the core over a valid/ready handshake.
- Drives the RAM's rmem_rd/rmem_wr/rop_a/rop_b strobes one byte per cycle, little-endian, and assembles read bytes from d_out into a sign- or zero-extended response.
- Sits between the execute stage and the RAM.

Parameters:
- MEM_DEPTH, 32, number of byte locations in the RAM; legal addresses are 0..MEM_DEPTH-1.

Ports:
- clk  in  1  clock
- rst_en  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  8  byte address
- req_wdata  in  32  store data, low bytes used
- rsp_valid  out  1  single-cycle response pulse, no backpressure
- rsp_err  out  1  request rejected, qualified by rsp_valid
- rsp_rdata  out  32  load result, 0 for stores and errors
- rmem_rd  out  1  RAM read strobe
- rmem_wr  out  1  RAM write strobe
- rop_a  out  8  RAM write byte
- rop_b  out  32  RAM byte address, bits 31:8 always 0
- d_out  in  32  RAM read data; bits 7:0 valid one cycle after a read

Behaviour:
- Reset: the asynchronous reset takes effect immediately.
  - State returns to IDLE.
  - All outputs are 0 except req_ready, which is 1.
  - Byte counter and assembly register are cleared.
- All outputs are registered. rmem_rd and rmem_wr are never high in the same cycle.
- States: IDLE, WR, RD, DRAIN, RESP.
- req_ready = 1 only in IDLE. Acceptance happens at a clock edge where req_valid && req_ready. Cycle 1 is the first cycle after acceptance.
- N = 1, 2 or 4 bytes by req_size. Byte k goes to address req_addr+k and maps to bits 8k+7:8k.
- Error check: if req_addr+N-1 > MEM_DEPTH-1, or req_size==3:
  - IDLE goes straight to RESP.
  - Cycle 1 has rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - No RAM strobe is issued.
- Store: WR state for cycles 1..N.
  - rmem_wr=1 in each of those cycles.
  - Cycle k+1 carries rop_b=req_addr+k and rop_a=byte k.
  - RESP in cycle N+1 with rsp_valid=1, rsp_err=0, rsp_rdata=0.
- Load: RD state for cycles 1..N with rmem_rd=1 and rop_b=req_addr+k in cycle k+1.
  - d_out[7:0] for byte k is sampled at the end of cycle k+2, so reads are pipelined one behind issue.
  - Cycle N+1 is DRAIN: no strobe, last byte captured.
  - RESP in cycle N+2 with rsp_valid=1 and rsp_rdata extended per req_unsigned/req_size.
- RESP always returns to IDLE next cycle, so req_ready rises one cycle after rsp_valid.
- Back-to-back throughput:
  - word store: 1 request per 6 cycles
  - word load: 1 request per 7 cycles
- Request fields are latched at acceptance; input changes afterwards are ignored.
- Reset mid-operation: the operation is abandoned with no response. Bytes already written to the RAM stay written, so a partial store is architecturally visible.
- d_out[31:8] is ignored.

Optional Feature:
- MISALIGN_TRAP_EN
  - Defined: a half at an odd address, or a word with addr[1:0]!=0, takes the error path (rsp_err=1 in cycle 1, no strobes).
  - Undefined: misaligned accesses are sequenced byte by byte like aligned ones, subject only to the range check.

Decomposition:
- ram_lsu_pkg holds:
  - the size enum (SZ_BYTE, SZ_HALF, SZ_WORD)
  - the state enum
  - the MEM_DEPTH default constant
  - a function for sign/zero extension by size
- One sub-module, ram_lsu_ext: a combinational extender (assembled 32-bit value, size, unsigned → rsp_rdata), reused later by the core's load path.

Test Plan:
- Store word 0xDEADBEEF at addr 4: rmem_wr=1 for cycles 1-4 with (rop_b, rop_a) = (4,EF), (5,BE), (6,AD), (7,DE); rsp_valid, err=0 in cycle 5; req_ready=1 in cycle 6.
- Load word from addr 4 after the store above: rmem_rd in cycles 1-4 at addresses 4..7; rsp_valid in cycle 6 with rsp_rdata=0xDEADBEEF.
- Load byte from addr 7: signed gives 0xFFFFFFDE; unsigned gives 0x000000DE; signed half from addr 6 gives 0xFFFFDEAD.
- Range errors:
  - Word load at addr 30 → rsp_err=1 in cycle 1, rsp_rdata=0, no rmem_rd.
  - Half at addr 30 → succeeds.
  - req_size=3 → error.
- Reset mid-store: assert rst_en during cycle 3 of a word store at addr 8. Outputs go to 0 and req_ready=1 immediately; no rsp_valid; a subsequent load shows bytes 8-9 written and bytes 10-11 unchanged.
- With MISALIGN_TRAP_EN: word load at addr 5 → err in cycle 1. Without it: data from bytes 5..8 returned in cycle 6.
